// File: rtl/ame_pkg.sv
// Shared types and helpers for the AME Gaussian-elimination solver.
package ame_pkg;

  localparam int unsigned AME_NUM_ROWS = 6;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StLat,
    StCmp,
    StUpd,
    StDone
  } ame_piv_state_t;

  // Index of the lowest cleared bit; 0 when every bit is set.
  function automatic logic [2:0] ame_first_zero(input logic [AME_NUM_ROWS-1:0] mask);
    ame_first_zero = 3'd0;
    for (int i = AME_NUM_ROWS - 1; i >= 0; i--) begin
      if (!mask[i]) ame_first_zero = 3'(i);
    end
  endfunction

endpackage

// File: rtl/ame_pivot_select.sv
// Pivot-search sequencer: walks the columns, drives the max-abs comparator with
// already-used rows masked, and records the pivot permutation and singularity.
module ame_pivot_select
  import ame_pkg::*;
#(
  parameter int unsigned COMP_DATA_BITS     = 64,
  parameter int unsigned COMP_DATA_IDX_BITS = 3
) (
  input  logic                                         clk_i,
  input  logic                                         rst_n_i,
  input  logic                                         piv_init_i,
  input  logic [2:0]                                   piv_cols_i,
  output logic                                         piv_done_o,
  output logic                                         col_rd_o,
  output logic [2:0]                                   col_addr_o,
  input  logic [5:0][COMP_DATA_BITS-1:0]               col_data_i,
  output logic                                         comp_init_o,
  input  logic                                         comp_done_i,
  output logic [5:0][COMP_DATA_BITS-1:0]               comp_data_o,
  output logic [5:0]                                   comp_data_mask_o,
  input  logic [COMP_DATA_BITS-1:0]                    comp_data_i,
  input  logic [COMP_DATA_IDX_BITS-1:0]                comp_data_index_i,
  output logic                                         piv_valid_o,
  output logic [2:0]                                   piv_col_o,
  output logic [COMP_DATA_IDX_BITS-1:0]                piv_row_o,
  output logic [5:0][COMP_DATA_IDX_BITS-1:0]           piv_perm_o,
  output logic                                         piv_singular_o
);

  ame_piv_state_t                        state_q, state_d;
  logic [2:0]                            n_q, n_d;
  logic [2:0]                            k_q, k_d;
  logic [5:0]                            mask_q, mask_d;
  logic [5:0][COMP_DATA_BITS-1:0]        data_q, data_d;
  logic [COMP_DATA_BITS-1:0]             max_q, max_d;
  logic [COMP_DATA_IDX_BITS-1:0]         idx_q, idx_d;
  logic [5:0][COMP_DATA_IDX_BITS-1:0]    perm_q, perm_d;
  logic                                  sing_q, sing_d;
  logic [COMP_DATA_IDX_BITS-1:0]         row;
  logic [2:0]                            n_eff;

  // Pivot row choice: comparator index, or lowest free row when the column is all zero.
  always_comb begin
    row   = (max_q != '0) ? idx_q : COMP_DATA_IDX_BITS'(ame_first_zero(mask_q));
    n_eff = (piv_cols_i == 3'd7) ? 3'd6 : piv_cols_i;
  end

  // Next-state logic for the search sequencer.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    mask_d  = mask_q;
    data_d  = data_q;
    max_d   = max_q;
    idx_d   = idx_q;
    perm_d  = perm_q;
    sing_d  = sing_q;
    unique case (state_q)
      StIdle: begin
        if (piv_init_i) begin
          n_d    = n_eff;
          k_d    = 3'd0;
          sing_d = 1'b0;
          perm_d = '0;
          for (int r = 0; r < AME_NUM_ROWS; r++) begin
            mask_d[r] = (3'(r) >= n_eff);
          end
          state_d = (n_eff == 3'd0) ? StDone : StRd;
        end
      end
      StRd: state_d = StLat;
      StLat: begin
        data_d  = col_data_i;
        state_d = StCmp;
      end
      StCmp: begin
        if (comp_done_i) begin
          max_d   = comp_data_i;
          idx_d   = comp_data_index_i;
          state_d = StUpd;
        end
      end
      StUpd: begin
        perm_d[k_q]      = row;
        mask_d[3'(row)]  = 1'b1;
        if (max_q == '0) sing_d = 1'b1;
        k_d     = k_q + 3'd1;
        state_d = ((k_q + 3'd1) < n_q) ? StRd : StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any search in progress.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      n_q     <= '0;
      k_q     <= '0;
      mask_q  <= '0;
      data_q  <= '0;
      max_q   <= '0;
      idx_q   <= '0;
      perm_q  <= '0;
      sing_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
      perm_q  <= perm_d;
      sing_q  <= sing_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    col_rd_o         = (state_q == StRd);
    col_addr_o       = col_rd_o ? k_q : 3'd0;
    comp_init_o      = (state_q == StCmp);
    comp_data_o      = data_q;
    comp_data_mask_o = mask_q;
    piv_valid_o      = (state_q == StUpd);
    piv_col_o        = piv_valid_o ? k_q : 3'd0;
    piv_row_o        = piv_valid_o ? row : '0;
    piv_perm_o       = perm_q;
    piv_singular_o   = sing_q;
    piv_done_o       = (state_q == StDone);
  end

endmodule

// File: doc/ame_pivot_select.md
# ame_pivot_select

Pivot-search sequencer for the AME 6-row Gaussian-elimination solver. For each column it reads the column from the matrix store and drives the max-abs comparator through its init/done handshake, masking rows already chosen. It records each pivot row, reports each pivot as it is found, and flags singularity. It sits between the coefficient-matrix register file and the elimination datapath, and acts as the initiator for the comparator's `comp_*` interface.

## Interface
Parameters:
- `COMP_DATA_BITS`, default 64: coefficient width (two's complement).
- `COMP_DATA_IDX_BITS`, default 3: row-index width.

Ports:
- `clk_i`: input, 1 bit. Single clock.
- `rst_n_i`: input, 1 bit. Reset is asynchronous and active-low.
- `piv_init_i`: input, 1 bit. Start pulse; sampled only in IDLE.
- `piv_cols_i`: input, 3 bits. Matrix order n, sampled with `piv_init_i`.
- `piv_done_o`: output, 1 bit. One-cycle pulse when the search ends.
- `col_rd_o`: output, 1 bit. Column read strobe to the matrix store.
- `col_addr_o`: output, 3 bits. Column index k.
- `col_data_i`: input, [5:0][COMP_DATA_BITS-1:0]. Column data, valid exactly 1 cycle after `col_rd_o`.
- `comp_init_o`: output, 1 bit. Comparator request; held until done.
- `comp_done_i`: input, 1 bit. Comparator completion; may be combinational from `comp_init_o`.
- `comp_data_o`: output, [5:0][COMP_DATA_BITS-1:0]. Registered column sent to the comparator.
- `comp_data_mask_o`: output, 6 bits. Bit r set means row r is excluded.
- `comp_data_i`: input, COMP_DATA_BITS. Max absolute value.
- `comp_data_index_i`: input, COMP_DATA_IDX_BITS. Row of the maximum.
- `piv_valid_o`: output, 1 bit. One-cycle pulse per resolved column.
- `piv_col_o`: output, 3 bits. Column k of the current pivot.
- `piv_row_o`: output, COMP_DATA_IDX_BITS. Pivot row for column k.
- `piv_perm_o`: output, [5:0][COMP_DATA_IDX_BITS-1:0]. Pivot row per column; entries for k ≥ n are 0.
- `piv_singular_o`: output, 1 bit. Sticky; set if any column's maximum is 0.

## Operation
- State machine states are IDLE, RD, LAT, CMP, UPD and DONE.
- IDLE → DONE if `piv_init_i` is high and n = 0.
- IDLE → RD if `piv_init_i` is high and n ≥ 1. Values n = 7 are treated as 6.
- On start:
  - mask := rows ≥ n set (e.g. n=4 → 6'b110000);
  - k := 0;
  - `piv_singular_o` := 0;
  - `piv_perm_o` := 0.
- RD: `col_rd_o` = 1 and `col_addr_o` = k. Next state is LAT.
- LAT: `col_data_i` is captured into `comp_data_o`. Next state is CMP.
- CMP: `comp_init_o` = 1, with `comp_data_mask_o` = mask. The result is captured in the cycle where `comp_done_i` = 1, then the state moves to UPD. The block waits indefinitely otherwise.
- UPD:
  - If the captured maximum ≠ 0: row := `comp_data_index_i`.
  - If the captured maximum = 0: row := lowest-numbered unmasked row, and `piv_singular_o` := 1.
  - `piv_valid_o` = 1, `piv_col_o` = k, `piv_row_o` = row.
  - `piv_perm_o[k]` := row, mask[row] := 1, k := k+1.
  - Next state is RD if k+1 < n, else DONE.
- DONE: `piv_done_o` = 1. Next state is IDLE.
- `piv_init_i` outside IDLE is ignored.
- `piv_perm_o` and `piv_singular_o` hold their values until the next start.
- Reset values: all outputs 0, the mask register is 0, and the state is IDLE.
- Asserting `rst_n_i` mid-search aborts immediately. No `piv_done_o` is produced.

## Timing
- With `piv_init_i` at cycle T:
  - `col_rd_o` is high at T+1;
  - `comp_init_o` is high at T+3 (earliest);
  - `piv_valid_o` is high at T+4 + (comparator wait cycles).
- Each column takes 4 cycles with a combinational-done comparator.
- `piv_done_o` occurs at T+4n+1 with zero-wait compares. For n=0 it occurs at T+1.
- `comp_data_o` and `comp_data_mask_o` are stable throughout CMP.
- `comp_init_o` drops in the cycle after done is observed.

## Structure
- Shared `ame_pkg` holds:
  - the state enum `ame_piv_state_t`;
  - `AME_NUM_ROWS` = 6;
  - a function `ame_first_zero(mask)` that returns the lowest cleared bit index.
- No sub-module is needed. The comparator is instantiated beside this block, not inside it.

## Test plan
- Identity 6×6 (diagonal 1, rest 0), n=6 → `piv_perm_o` = {0,1,2,3,4,5}, singular=0, `piv_done_o` at T+25.
- n=3, column 0 = {2,-9,5,x,x,x}:
  - comparator sees mask 6'b111000 and the reported pivot is row 1;
  - column 1 sees mask 6'b111010.
- Column 1 all zero on unmasked rows, n=4, row 0 already used → pivot row 1, `piv_singular_o`=1, and the search continues to done.
- Comparator done delayed by 3 cycles → `comp_init_o` is held and `comp_data_o` is stable. `piv_valid_o` arrives 3 cycles later; perm is unchanged versus zero-wait.
- Reset asserted in CMP of column 2 → all outputs 0 asynchronously. A new `piv_init_i` with n=2 completes normally.
- `piv_init_i` pulsed during the search and n=0 → the mid-run pulse is ignored. The n=0 start gives `piv_done_o` at T+1 with no `col_rd_o`.
